// File: rtl/ahb_lite_sram_ctrl_p_if.sv
// AHB-Lite slave-side bus bundle for ahb_lite_sram_ctrl_p.
// Clock and reset are kept as plain ports on the controller.
interface ahb_lite_sram_ctrl_p_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic [1:0]  HRESP;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    input  HRDATA, HREADYOUT, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    output HRDATA, HREADYOUT, HRESP
  );
endinterface

// File: rtl/ahb_lite_sram_ctrl_p.sv
// AHB-Lite word-organised SRAM slave: wait states, byte-lane writes, pipelined transfers.
// Define AHB_MEM_ERR_EN to get the two-cycle ERROR response for illegal transfers.
module ahb_lite_sram_ctrl_p_lane #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);
  logic [7:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk)
    if (we) mem[addr] <= wdata;

  // Asynchronous read lets a write committed on the same edge be seen by the next data phase.
  assign rdata = mem[addr];
endmodule

module ahb_lite_sram_ctrl_p #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 0
) (
  input logic                   HCLK,
  input logic                   HRESETn,
  ahb_lite_sram_ctrl_p_if.slave bus
);
  localparam int AW        = $clog2(DEPTH_WORDS);
  localparam int NUM_LANES = 4;

  typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_DATA, ST_ERR1, ST_ERR2} state_t;

  state_t                     state;
  logic [AW-1:0]              addr_q;
  logic                       write_q;
  logic [NUM_LANES-1:0]       mask_q, mask_d, lane_we;
  logic [2:0]                 wcnt;
  logic                       hready_q;
  logic [1:0]                 hresp_q;
  logic [31:0]                rd_hold;
  logic [NUM_LANES-1:0][7:0]  rdata_w;
  logic                       accept, illegal, commit;
  logic                       unused;

  assign unused = ^{bus.HADDR, bus.HTRANS[0]};

  // hready_q gate keeps WAIT/ERR1 from accepting even if HREADY is wired oddly.
  assign accept = bus.HSEL & bus.HREADY & bus.HTRANS[1] & hready_q;

  always_comb begin
    mask_d = 4'b1111;
    case (bus.HSIZE)
      3'b000:  mask_d = 4'b0001 << bus.HADDR[1:0];
      3'b001:  mask_d = bus.HADDR[1] ? 4'b1100 : 4'b0011;
      default: mask_d = 4'b1111;
    endcase
  end

`ifdef AHB_MEM_ERR_EN
  assign illegal = (bus.HADDR >= 32'(4 * DEPTH_WORDS)) | (bus.HSIZE > 3'b010) |
                   ((bus.HSIZE == 3'b001) & bus.HADDR[0]) |
                   ((bus.HSIZE == 3'b010) & (bus.HADDR[1:0] != 2'b00));
`else
  assign illegal = 1'b0;
`endif

  assign commit  = (state == ST_DATA) & write_q;
  assign lane_we = {NUM_LANES{commit}} & mask_q;

  ahb_lite_sram_ctrl_p_lane #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_lane [NUM_LANES-1:0] (
    .clk   (HCLK),
    .we    (lane_we),
    .addr  (addr_q),
    .wdata (bus.HWDATA),
    .rdata (rdata_w)
  );

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state    <= ST_IDLE;
      addr_q   <= '0;
      write_q  <= 1'b0;
      mask_q   <= '0;
      wcnt     <= '0;
      hready_q <= 1'b1;
      hresp_q  <= 2'b00;
      rd_hold  <= '0;
    end else begin
      if (state == ST_DATA && !write_q) rd_hold <= rdata_w;
      case (state)
        ST_WAIT: begin
          if (wcnt == 3'd1) begin
            state    <= ST_DATA;
            hready_q <= 1'b1;
            wcnt     <= '0;
          end else begin
            wcnt <= wcnt - 3'd1;
          end
        end
        ST_ERR1: begin
          state    <= ST_ERR2;
          hready_q <= 1'b1;
        end
        default: begin  // IDLE, DATA and ERR2 all launch the next address phase
          if (accept) begin
            addr_q  <= bus.HADDR[AW+1:2];
            write_q <= bus.HWRITE;
            mask_q  <= mask_d;
            if (illegal) begin
              state    <= ST_ERR1;
              hready_q <= 1'b0;
              hresp_q  <= 2'b01;
              if (!bus.HWRITE) rd_hold <= '0;
            end else if (WAIT_STATES > 0) begin
              state    <= ST_WAIT;
              wcnt     <= 3'(WAIT_STATES);
              hready_q <= 1'b0;
              hresp_q  <= 2'b00;
            end else begin
              state    <= ST_DATA;
              hready_q <= 1'b1;
              hresp_q  <= 2'b00;
            end
          end else begin
            state    <= ST_IDLE;
            hready_q <= 1'b1;
            hresp_q  <= 2'b00;
          end
        end
      endcase
    end
  end

  assign bus.HREADYOUT = hready_q;
  assign bus.HRESP     = hresp_q;
  assign bus.HRDATA    = (state == ST_DATA && !write_q) ? rdata_w : rd_hold;
endmodule

// File: tb/tb_ahb_lite_sram_ctrl_p.sv
// Bench for ahb_lite_sram_ctrl_p: three configurations behind one pipelined AHB driver,
// with expected responses queued at address phase and checked at data-phase completion.
module tb_ahb_lite_sram_ctrl_p;
  logic HCLK = 1'b0;
  logic HRESETn = 1'b1;
  always #5 HCLK = ~HCLK;

  ahb_lite_sram_ctrl_p_if i0();
  ahb_lite_sram_ctrl_p_if i1();
  ahb_lite_sram_ctrl_p_if i2();

  int          dsel = 0;
  logic        hsel = 1'b0, hwrite = 1'b0;
  logic [31:0] haddr = '0, hwdata = '0;
  logic [1:0]  htrans = 2'b00;
  logic [2:0]  hsize = 3'b000;

  assign i0.HSEL = hsel & (dsel == 0);
  assign i1.HSEL = hsel & (dsel == 1);
  assign i2.HSEL = hsel & (dsel == 2);
  assign i0.HADDR = haddr;   assign i1.HADDR = haddr;   assign i2.HADDR = haddr;
  assign i0.HTRANS = htrans; assign i1.HTRANS = htrans; assign i2.HTRANS = htrans;
  assign i0.HWRITE = hwrite; assign i1.HWRITE = hwrite; assign i2.HWRITE = hwrite;
  assign i0.HSIZE = hsize;   assign i1.HSIZE = hsize;   assign i2.HSIZE = hsize;
  assign i0.HWDATA = hwdata; assign i1.HWDATA = hwdata; assign i2.HWDATA = hwdata;
  assign i0.HREADY = i0.HREADYOUT;
  assign i1.HREADY = i1.HREADYOUT;
  assign i2.HREADY = i2.HREADYOUT;

  ahb_lite_sram_ctrl_p #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) u_d0 (.HCLK(HCLK), .HRESETn(HRESETn), .bus(i0.slave));
  ahb_lite_sram_ctrl_p #(.DEPTH_WORDS(1024), .WAIT_STATES(2)) u_d1 (.HCLK(HCLK), .HRESETn(HRESETn), .bus(i1.slave));
  ahb_lite_sram_ctrl_p #(.DEPTH_WORDS(16),   .WAIT_STATES(0)) u_d2 (.HCLK(HCLK), .HRESETn(HRESETn), .bus(i2.slave));

  logic        rdy;
  logic [1:0]  resp;
  logic [31:0] rdata;
  always_comb begin
    rdy = i0.HREADYOUT; resp = i0.HRESP; rdata = i0.HRDATA;
    if (dsel == 1) begin
      rdy = i1.HREADYOUT; resp = i1.HRESP; rdata = i1.HRDATA;
    end else if (dsel == 2) begin
      rdy = i2.HREADYOUT; resp = i2.HRESP; rdata = i2.HRDATA;
    end
  end

  typedef struct { bit rd; logic [31:0] data; logic [1:0] resp; int waits; } exp_t;

  int          nvec = 0, nmis = 0;
  exp_t        sbq[$];
  bit          pend = 1'b0;
  logic [31:0] mdl [int];
  logic [31:0] last_rd = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic int depth_of(input int d);
    return (d == 2) ? 16 : 1024;
  endfunction

  function automatic int waits_of(input int d);
    return (d == 1) ? 2 : 0;
  endfunction

  function automatic bit bad_xfer(input logic [31:0] a, input logic [2:0] sz, input int dep);
    bit b;
    b = (a >= 32'(4 * dep)) || (sz > 3'd2) || (sz == 3'd1 && a[0]) ||
        (sz == 3'd2 && a[1:0] != 2'b00);
`ifndef AHB_MEM_ERR_EN
    b = 1'b0;
`endif
    return b;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [1:0] lo, input logic [2:0] sz);
    logic [3:0]  m;
    logic [31:0] r;
    r = old;
    if (sz == 3'd0)      m = 4'b0001 << lo;
    else if (sz == 3'd1) m = lo[1] ? 4'b1100 : 4'b0011;
    else                 m = 4'b1111;
    for (int l = 0; l < 4; l++)
      if (m[l]) r[8*l +: 8] = wd[8*l +: 8];
    return r;
  endfunction

  // One bus cycle: present an address phase (or idle), finish the pending data phase.
  task automatic xfer(input bit act, input bit wr, input logic [31:0] a,
                      input logic [2:0] sz, input logic [31:0] wd);
    int   n, lows, dep, key;
    exp_t e;
    n = 0; lows = 0;
    hsel = act; htrans = act ? 2'b10 : 2'b00; haddr = a; hwrite = wr; hsize = sz;
    do begin
      @(negedge HCLK);
      n++;
      if (pend && sbq.size() > 0) chk("resp", 32'(resp), 32'(sbq[0].resp));
      if (!rdy) lows++;
    end while (!rdy && n < 20);
    if (!rdy) begin
      chk("timeout", 32'(rdy), 32'd1);
      pend = 1'b0;
      sbq.delete();
    end else begin
      if (pend) begin
        e = sbq.pop_front();
        chk("waits", 32'(lows), 32'(e.waits));
        if (e.rd) begin
          chk("rdata", rdata, e.data);
          last_rd = e.data;
        end
        pend = 1'b0;
      end
      if (act) begin
        dep = depth_of(dsel);
        key = (dsel << 20) | (int'(a[31:2]) % dep);
        e.rd = !wr; e.data = '0; e.resp = 2'b00; e.waits = waits_of(dsel);
        if (bad_xfer(a, sz, dep)) begin
          e.resp = 2'b01; e.waits = 1;
        end else if (wr) begin
          mdl[key] = merge(mdl.exists(key) ? mdl[key] : 32'h0, wd, a[1:0], sz);
        end else begin
          e.data = mdl[key];
        end
        sbq.push_back(e);
        pend = 1'b1;
      end
    end
    @(posedge HCLK); #1;
    if (act && wr) hwdata = wd;
    hsel = 1'b0; htrans = 2'b00;
  endtask

  initial begin
    #2 HRESETn = 1'b0;
    #1;
    chk("rst_ready", 32'(rdy), 32'd1);
    chk("rst_resp",  32'(resp), 32'd0);
    chk("rst_rdata", rdata, 32'h0);
    repeat (2) @(negedge HCLK);
    HRESETn = 1'b1;
    @(posedge HCLK); #1;

    // zero-wait: word, byte and halfword lanes, oversize treated per configuration
    dsel = 0;
    xfer(1, 1, 32'h8,  3'd2, 32'hA5A5A5A5);
    xfer(1, 0, 32'h8,  3'd2, 32'h0);
    xfer(1, 1, 32'h9,  3'd0, 32'h00003C00);
    xfer(1, 0, 32'h8,  3'd2, 32'h0);
    xfer(1, 1, 32'hA,  3'd1, 32'hBEEF0000);
    xfer(1, 0, 32'h8,  3'd2, 32'h0);
    xfer(1, 1, 32'h30, 3'd2, 32'hFFFF0000);
    xfer(1, 1, 32'h30, 3'd3, 32'h01020304);
    xfer(1, 0, 32'h30, 3'd2, 32'h0);
    xfer(0, 0, 32'h0,  3'd0, 32'h0);
    @(negedge HCLK);
    chk("hold", rdata, last_rd);
    @(posedge HCLK); #1;
    // out-of-range word: ERROR when checking is on, wraps to word 0 otherwise
    xfer(1, 1, 32'h0,    3'd2, 32'h55AA55AA);
    xfer(1, 1, 32'h1000, 3'd2, 32'hFFFFFFFF);
    xfer(1, 0, 32'h0,    3'd2, 32'h0);
    xfer(1, 0, 32'h0,    3'd2, 32'h0);
    xfer(0, 0, 32'h0,    3'd0, 32'h0);

    // two wait states, pipelined write/read
    dsel = 1;
    xfer(1, 1, 32'h8,  3'd2, 32'h600DF00D);
    xfer(1, 0, 32'h8,  3'd2, 32'h0);
    xfer(0, 0, 32'h0,  3'd0, 32'h0);
    xfer(1, 1, 32'h10, 3'd2, 32'h13572468);
    xfer(1, 0, 32'h10, 3'd2, 32'h0);
    xfer(0, 0, 32'h0,  3'd0, 32'h0);
    xfer(1, 1, 32'h20, 3'd2, 32'hCAFEF00D);
    xfer(0, 0, 32'h0,  3'd0, 32'h0);

    // reset in the second wait cycle of a write aborts it
    hsel = 1'b1; htrans = 2'b10; haddr = 32'h20; hwrite = 1'b1; hsize = 3'd2;
    @(negedge HCLK);
    @(posedge HCLK); #1;
    hwdata = 32'hDEADBEEF; hsel = 1'b0; htrans = 2'b00;
    @(posedge HCLK); #1;
    chk("abort_wait", 32'(rdy), 32'd0);
    HRESETn = 1'b0;
    #1;
    chk("abort_ready", 32'(rdy), 32'd1);
    chk("abort_resp",  32'(resp), 32'd0);
    chk("abort_rdata", rdata, 32'h0);
    @(negedge HCLK);
    HRESETn = 1'b1;
    @(posedge HCLK); #1;
    xfer(1, 0, 32'h20, 3'd2, 32'h0);
    xfer(0, 0, 32'h0,  3'd0, 32'h0);

    // 16-word array: address wraps modulo depth
    dsel = 2;
    xfer(1, 1, 32'h0,  3'd2, 32'h22222222);
    xfer(1, 1, 32'h40, 3'd2, 32'h11111111);
    xfer(1, 0, 32'h0,  3'd2, 32'h0);
    xfer(0, 0, 32'h0,  3'd0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
